imem_fetch_arbiter: RTL and testbench

- Shares the single instruction-memory fetch port among NUM_REQ fetch requesters (one per warp).
- Round-robin arbitration, one request per cycle to the imem port.
- Tags each request with requester ID and epoch; routes responses back by tag.
- Limits per-requester outstanding fetches; per-requester flush discards in-flight responses by epoch.

---
 rtl/imem_fetch_arbiter_if.sv | 39 +++
 rtl/imem_fetch_arbiter.sv | 151 +++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_arbiter_if.sv
// Bundle of the requester-side fetch signals and the shared imem port.
// slave: the arbiter's view; master: whoever drives requesters and imem.
interface imem_fetch_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int ARCH_LEN       = 32,
  parameter int INST_BITS      = 64,
  parameter int IMEM_TAG_BITS  = 64,
  parameter int LOCAL_TAG_BITS = 8
);
  logic [NUM_REQ-1:0]                in_req_valid;
  logic [NUM_REQ-1:0]                in_req_ready;
  logic [NUM_REQ*ARCH_LEN-1:0]       in_req_pc;
  logic [NUM_REQ*LOCAL_TAG_BITS-1:0] in_req_tag;
  logic [NUM_REQ-1:0]                in_flush;
  logic [NUM_REQ-1:0]                in_resp_valid;
  logic [NUM_REQ*LOCAL_TAG_BITS-1:0] in_resp_tag;
  logic [INST_BITS-1:0]              in_resp_inst;
  logic                              imem_req_valid;
  logic [IMEM_TAG_BITS-1:0]          imem_req_bits_tag;
  logic [ARCH_LEN-1:0]               imem_req_bits_pc;
  logic                              imem_resp_valid;
  logic [IMEM_TAG_BITS-1:0]          imem_resp_bits_tag;
  logic [INST_BITS-1:0]              imem_resp_bits_inst;
  logic                              busy;

  modport slave (
    input  in_req_valid, in_req_pc, in_req_tag, in_flush,
           imem_resp_valid, imem_resp_bits_tag, imem_resp_bits_inst,
    output in_req_ready, in_resp_valid, in_resp_tag, in_resp_inst,
           imem_req_valid, imem_req_bits_tag, imem_req_bits_pc, busy
  );

  modport master (
    output in_req_valid, in_req_pc, in_req_tag, in_flush,
           imem_resp_valid, imem_resp_bits_tag, imem_resp_bits_inst,
    input  in_req_ready, in_resp_valid, in_resp_tag, in_resp_inst,
           imem_req_valid, imem_req_bits_tag, imem_req_bits_pc, busy
  );
endinterface

// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing one imem fetch port among NUM_REQ requesters.
// Requests carry {epoch, requester id, local tag}; responses are routed by
// id and dropped when their epoch is stale (requester flushed since issue).
module imem_fetch_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ARCH_LEN        = 32,
  parameter int INST_BITS       = 64,
  parameter int IMEM_TAG_BITS   = 64,
  parameter int LOCAL_TAG_BITS  = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic                  clock,
  input logic                  reset,
  imem_fetch_arbiter_if.slave  bus
);
  localparam int ID_BITS  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_BITS = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_OUTSTANDING);

  logic [CNT_BITS-1:0]       r_cnt [NUM_REQ];
  logic [NUM_REQ-1:0]        r_epoch;
  logic [ID_BITS-1:0]        r_rr_ptr;

  logic [NUM_REQ-1:0]        w_elig;
  logic [NUM_REQ-1:0]        w_grant_vec;
  logic                      w_grant_any;
  logic [ID_BITS-1:0]        w_grant_id;
  logic [ARCH_LEN-1:0]       w_req_pc;
  logic [LOCAL_TAG_BITS-1:0] w_req_lt;
  logic                      w_req_ep;

  logic [LOCAL_TAG_BITS-1:0] w_resp_lt;
  logic [ID_BITS-1:0]        w_resp_id;
  logic                      w_resp_ep;
  logic                      w_resp_ok;
  logic [NUM_REQ-1:0]        w_resp_hit;
  logic [NUM_REQ-1:0]        w_deliver;
  logic [NUM_REQ-1:0]        w_cnt_dec;
  logic                      w_any_cnt;
  logic [IMEM_TAG_BITS-1:0]  w_unused_resp_tag;

  // A requester may issue only below its outstanding limit and not while flushing.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = bus.in_req_valid[i] && (r_cnt[i] < MAX_CNT) && !bus.in_flush[i] && !reset;
    end
  end

  // Pick the first eligible requester starting at the round-robin pointer.
  always_comb begin : grant_scan
    int idx;
    idx         = 0;
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_grant_vec = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_grant_any && idx == i && w_elig[i]) begin
          w_grant_any    = 1'b1;
          w_grant_id     = ID_BITS'(i);
          w_grant_vec[i] = 1'b1;
        end
      end
    end
  end

  // Steer the granted requester's PC, local tag and epoch onto the imem port.
  always_comb begin
    w_req_pc = '0;
    w_req_lt = '0;
    w_req_ep = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_vec[i]) begin
        w_req_pc = bus.in_req_pc[i*ARCH_LEN +: ARCH_LEN];
        w_req_lt = bus.in_req_tag[i*LOCAL_TAG_BITS +: LOCAL_TAG_BITS];
        w_req_ep = r_epoch[i];
      end
    end
  end

  assign bus.in_req_ready      = w_grant_vec;
  assign bus.imem_req_valid    = w_grant_any;
  assign bus.imem_req_bits_pc  = w_req_pc;
  assign bus.imem_req_bits_tag = w_grant_any ? IMEM_TAG_BITS'({w_req_ep, w_grant_id, w_req_lt}) : '0;

  // Tag bits above the packed fields carry nothing the arbiter needs.
  assign w_unused_resp_tag = bus.imem_resp_bits_tag;
  assign w_resp_lt = bus.imem_resp_bits_tag[LOCAL_TAG_BITS-1:0];
  assign w_resp_id = bus.imem_resp_bits_tag[LOCAL_TAG_BITS +: ID_BITS];
  assign w_resp_ep = bus.imem_resp_bits_tag[LOCAL_TAG_BITS + ID_BITS];
  assign w_resp_ok = bus.imem_resp_valid && !reset;

  // Ids with no matching requester match nothing here and are dropped.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_resp_hit[i] = w_resp_ok && (w_resp_id == ID_BITS'(i));
      w_deliver[i]  = w_resp_hit[i] && (w_resp_ep == r_epoch[i]) && !bus.in_flush[i];
      w_cnt_dec[i]  = w_resp_hit[i] && (r_cnt[i] != '0);
    end
  end

  // Only current-epoch responses reach the requester; other tag slices read zero.
  always_comb begin
    bus.in_resp_tag = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_deliver[i]) begin
        bus.in_resp_tag[i*LOCAL_TAG_BITS +: LOCAL_TAG_BITS] = w_resp_lt;
      end
    end
  end

  assign bus.in_resp_valid = w_deliver;
  assign bus.in_resp_inst  = bus.imem_resp_bits_inst;

  // Busy while any requester still has a fetch in flight.
  always_comb begin
    w_any_cnt = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_any_cnt = w_any_cnt | (r_cnt[i] != '0);
    end
  end

  assign bus.busy = w_any_cnt && !reset;

  // Outstanding counters, flush epochs and round-robin pointer.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_cnt[i] <= '0;
      end
      r_epoch  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (w_grant_any) begin
        r_rr_ptr <= (w_grant_id == ID_BITS'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        // Decrement saturates at zero so stale pre-reset responses cannot underflow.
        if (w_grant_vec[i] && !w_cnt_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (w_cnt_dec[i] && !w_grant_vec[i]) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
        if (bus.in_flush[i]) begin
          r_epoch[i] <= ~r_epoch[i];
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: directed sequences plus a response scoreboard.
module tb_imem_fetch_arbiter;
  logic clock;
  logic reset;

  imem_fetch_arbiter_if #(.NUM_REQ(4)) bus ();
  imem_fetch_arbiter_if #(.NUM_REQ(3)) bus3 ();

  imem_fetch_arbiter #(.NUM_REQ(4)) u_dut (.clock(clock), .reset(reset), .bus(bus));
  imem_fetch_arbiter #(.NUM_REQ(3)) u_dut3 (.clock(clock), .reset(reset), .bus(bus3));

  typedef struct {
    int          id;
    logic [7:0]  lt;
    logic [63:0] inst;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [3:0] m_epoch;
  int   m_rr;
  int   prev_g;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pk(input logic ep, input logic [1:0] id, input logic [7:0] lt);
    return {53'b0, ep, id, lt};
  endfunction

  // Advance to just after the next rising edge; update the epoch model and
  // drop any single-cycle imem response.
  task automatic next_cycle();
    @(posedge clock);
    #1;
    if (reset) m_epoch = '0;
    else m_epoch = m_epoch ^ bus.in_flush;
    bus.imem_resp_valid  = 1'b0;
    bus3.imem_resp_valid = 1'b0;
  endtask

  task automatic drive_resp(input logic ep, input int id, input logic [7:0] lt, input logic [63:0] inst);
    bus.imem_resp_valid     = 1'b1;
    bus.imem_resp_bits_tag  = pk(ep, 2'(id), lt);
    bus.imem_resp_bits_inst = inst;
    if (!reset && ep == m_epoch[id] && !bus.in_flush[id]) exp_q.push_back('{id, lt, inst});
  endtask

  // Scoreboard: anything pushed this cycle must appear on the requester side now.
  always @(negedge clock) begin
    if (!reset && (exp_q.size() > 0 || bus.in_resp_valid != '0)) begin
      if (exp_q.size() == 0) begin
        check_val("resp_unexpected", 64'(bus.in_resp_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("resp_valid", 64'(bus.in_resp_valid), 64'(1 << mon_e.id));
        check_val("resp_tag", 64'(bus.in_resp_tag[mon_e.id*8 +: 8]), 64'(mon_e.lt));
        check_val("resp_inst", bus.in_resp_inst, mon_e.inst);
      end
    end
  end

  initial begin
    reset = 1'b1;
    m_epoch = '0;
    bus.in_req_valid = '0; bus.in_req_pc = '0; bus.in_req_tag = '0; bus.in_flush = '0;
    bus.imem_resp_valid = 1'b0; bus.imem_resp_bits_tag = '0; bus.imem_resp_bits_inst = '0;
    bus3.in_req_valid = '0; bus3.in_req_pc = '0; bus3.in_req_tag = '0; bus3.in_flush = '0;
    bus3.imem_resp_valid = 1'b0; bus3.imem_resp_bits_tag = '0; bus3.imem_resp_bits_inst = '0;

    // Reset: outputs held low even with requests and responses present.
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      bus.in_req_valid = 4'hF;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_bits_tag = pk(1'b0, 2'd1, 8'h05);
      @(negedge clock);
      check_val("rst_ready", 64'(bus.in_req_ready), 64'd0);
      check_val("rst_imem_valid", 64'(bus.imem_req_valid), 64'd0);
      check_val("rst_resp_valid", 64'(bus.in_resp_valid), 64'd0);
      check_val("rst_busy", 64'(bus.busy), 64'd0);
    end

    // Single request from requester 1, answered one cycle later.
    next_cycle();
    reset = 1'b0;
    bus.in_req_valid = 4'b0010;
    bus.in_req_pc[32 +: 32] = 32'h100;
    bus.in_req_tag[8 +: 8] = 8'h05;
    @(negedge clock);
    check_val("t1_ready", 64'(bus.in_req_ready), 64'h2);
    check_val("t1_imem_valid", 64'(bus.imem_req_valid), 64'd1);
    check_val("t1_imem_tag", bus.imem_req_bits_tag, 64'h105);
    check_val("t1_imem_pc", 64'(bus.imem_req_bits_pc), 64'h100);
    next_cycle();
    bus.in_req_valid = '0;
    drive_resp(1'b0, 1, 8'h05, 64'hAAAA_0000_0000_0001);
    @(negedge clock);
    check_val("t1_busy_inflight", 64'(bus.busy), 64'd1);
    next_cycle();
    @(negedge clock);
    check_val("t1_busy_drained", 64'(bus.busy), 64'd0);

    // All four requesting continuously: strict rotation from pointer 2.
    m_rr = 2;
    prev_g = -1;
    for (int i = 0; i < 4; i++) begin
      bus.in_req_pc[i*32 +: 32] = 32'h1000 + 32'(i * 16);
      bus.in_req_tag[i*8 +: 8] = 8'h30 + 8'(i);
    end
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      bus.in_req_valid = 4'hF;
      if (prev_g >= 0) drive_resp(m_epoch[prev_g], prev_g, 8'h30 + 8'(prev_g), {32'hC0DE_0000, 32'(k)});
      @(negedge clock);
      check_val("rr_ready", 64'(bus.in_req_ready), 64'(1 << m_rr));
      check_val("rr_pc", 64'(bus.imem_req_bits_pc), 64'h1000 + 64'(m_rr * 16));
      check_val("rr_tag", bus.imem_req_bits_tag, pk(m_epoch[m_rr], 2'(m_rr), 8'h30 + 8'(m_rr)));
      prev_g = m_rr;
      m_rr = (m_rr + 1) % 4;
    end
    next_cycle();
    bus.in_req_valid = '0;
    drive_resp(m_epoch[prev_g], prev_g, 8'h30 + 8'(prev_g), 64'hC0DE_0000_0000_00FF);
    next_cycle();
    @(negedge clock);
    check_val("rr_busy_drained", 64'(bus.busy), 64'd0);

    // Requester 2 alone with responses withheld: limited to two in flight.
    next_cycle();
    bus.in_req_valid = 4'b0100;
    @(negedge clock);
    check_val("lim_grant1", 64'(bus.in_req_ready), 64'h4);
    next_cycle();
    @(negedge clock);
    check_val("lim_grant2", 64'(bus.in_req_ready), 64'h4);
    next_cycle();
    @(negedge clock);
    check_val("lim_blocked", 64'(bus.in_req_ready), 64'h0);
    check_val("lim_imem_valid", 64'(bus.imem_req_valid), 64'd0);
    next_cycle();
    drive_resp(1'b0, 2, 8'h32, 64'hBBBB_0000_0000_0001);
    @(negedge clock);
    check_val("lim_resp_cycle", 64'(bus.in_req_ready), 64'h0);
    next_cycle();
    @(negedge clock);
    check_val("lim_reenabled", 64'(bus.in_req_ready), 64'h4);
    next_cycle();
    bus.in_req_valid = '0;
    drive_resp(1'b0, 2, 8'h32, 64'hBBBB_0000_0000_0002);
    next_cycle();
    drive_resp(1'b0, 2, 8'h32, 64'hBBBB_0000_0000_0003);
    next_cycle();
    @(negedge clock);
    check_val("lim_busy_drained", 64'(bus.busy), 64'd0);

    // Flush of requester 0 between two fetches: stale response dropped.
    next_cycle();
    bus.in_req_valid = 4'b0001;
    bus.in_req_pc[0 +: 32] = 32'h200;
    bus.in_req_tag[0 +: 8] = 8'h11;
    @(negedge clock);
    check_val("fl_ready_a", 64'(bus.in_req_ready), 64'h1);
    check_val("fl_tag_a", bus.imem_req_bits_tag, pk(1'b0, 2'd0, 8'h11));
    next_cycle();
    bus.in_flush = 4'b0001;
    @(negedge clock);
    check_val("fl_no_grant", 64'(bus.in_req_ready), 64'h0);
    next_cycle();
    bus.in_flush = '0;
    bus.in_req_tag[0 +: 8] = 8'h22;
    @(negedge clock);
    check_val("fl_ready_b", 64'(bus.in_req_ready), 64'h1);
    check_val("fl_tag_b", bus.imem_req_bits_tag, pk(1'b1, 2'd0, 8'h22));
    next_cycle();
    bus.in_req_valid = '0;
    drive_resp(1'b0, 0, 8'h11, 64'hDEAD_0000_0000_0011);
    @(negedge clock);
    check_val("fl_stale_drop", 64'(bus.in_resp_valid), 64'h0);
    check_val("fl_busy_a", 64'(bus.busy), 64'd1);
    next_cycle();
    drive_resp(1'b1, 0, 8'h22, 64'hBEEF_0000_0000_0022);
    @(negedge clock);
    check_val("fl_busy_b", 64'(bus.busy), 64'd1);
    next_cycle();
    @(negedge clock);
    check_val("fl_busy_drained", 64'(bus.busy), 64'd0);

    // Three-requester instance: id 3 matches nobody.
    next_cycle();
    bus3.in_req_valid = 3'b001;
    bus3.in_req_pc[0 +: 32] = 32'h300;
    bus3.in_req_tag[0 +: 8] = 8'h44;
    @(negedge clock);
    check_val("n3_ready", 64'(bus3.in_req_ready), 64'h1);
    next_cycle();
    bus3.in_req_valid = '0;
    bus3.imem_resp_valid = 1'b1;
    bus3.imem_resp_bits_tag = pk(1'b0, 2'd3, 8'h44);
    @(negedge clock);
    check_val("n3_badid_drop", 64'(bus3.in_resp_valid), 64'h0);
    next_cycle();
    @(negedge clock);
    check_val("n3_cnt_kept", 64'(bus3.busy), 64'd1);
    next_cycle();
    bus3.imem_resp_valid = 1'b1;
    bus3.imem_resp_bits_tag = pk(1'b0, 2'd0, 8'h44);
    @(negedge clock);
    check_val("n3_resp_valid", 64'(bus3.in_resp_valid), 64'h1);
    check_val("n3_resp_tag", 64'(bus3.in_resp_tag[0 +: 8]), 64'h44);
    next_cycle();
    @(negedge clock);
    check_val("n3_busy_drained", 64'(bus3.busy), 64'd0);

    // Reset with requester 1 holding two fetches in flight.
    next_cycle();
    bus.in_req_valid = 4'b0010;
    @(negedge clock);
    check_val("mr_grant1", 64'(bus.in_req_ready), 64'h2);
    next_cycle();
    @(negedge clock);
    check_val("mr_grant2", 64'(bus.in_req_ready), 64'h2);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      reset = 1'b1;
      bus.in_req_valid = 4'b0011;
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_bits_tag = pk(1'b0, 2'd1, 8'h05);
      @(negedge clock);
      check_val("mr_rst_ready", 64'(bus.in_req_ready), 64'h0);
      check_val("mr_rst_imem_valid", 64'(bus.imem_req_valid), 64'd0);
      check_val("mr_rst_resp_valid", 64'(bus.in_resp_valid), 64'h0);
      check_val("mr_rst_busy", 64'(bus.busy), 64'd0);
    end
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    check_val("mr_busy_clear", 64'(bus.busy), 64'd0);
    check_val("mr_grant0_first", 64'(bus.in_req_ready), 64'h1);
    check_val("mr_tag", bus.imem_req_bits_tag, pk(1'b0, 2'd0, 8'h22));
    next_cycle();
    bus.in_req_valid = '0;
    drive_resp(1'b0, 0, 8'h22, 64'h1234_0000_0000_0022);
    next_cycle();
    @(negedge clock);
    check_val("mr_busy_drained", 64'(bus.busy), 64'd0);

    check_val("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
